fsm_rr_arbiter: RTL



---
 rtl/fsm_rr_arbiter_pkg.sv | 21 ++
 rtl/fsm_rr_arbiter_if.sv | 14 +
 rtl/fsm_rr_arbiter_rr_priority_pick.sv | 34 +++
 rtl/fsm_rr_arbiter.sv | 108 ++++++++++
 4 files changed

// File: rtl/fsm_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Provides the FSM state encoding and an index-width function.
package fsm_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        TURN = 2'b10
    } state_e;

    // Never returns 0, so a 2-requester arbiter still gets a 1-bit index.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fsm_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The master side is the requesters; the slave side is the arbiter itself.
interface fsm_rr_arbiter_if #(
    parameter int unsigned N = 4
) ();
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [N-1:0] next_grant;
    logic         busy;
    logic         expired;

    modport master (output req, input grant, input next_grant, input busy, input expired);
    modport slave  (input req, output grant, output next_grant, output busy, output expired);
endinterface

// File: rtl/fsm_rr_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: the first requester at or after i_ptr, wrapping mod N.
// i_ptr must be below N.
module rr_priority_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_any
);
    localparam logic [IDX_W:0] N_V = (IDX_W + 1)'(N);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IDX_W:0] w_sum;

    always_comb begin
        // Rotate so bit 0 corresponds to the requester at i_ptr.
        w_dbl = {i_req, i_req} >> i_ptr;
        w_rot = w_dbl[N-1:0];
        o_any = |i_req;
        w_sum = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, i_ptr} + (IDX_W + 1)'(k);
            end
        end
        if (w_sum >= N_V) begin
            w_sum = w_sum - N_V;
        end
        o_winner = w_sum[IDX_W-1:0];
    end
endmodule

// File: rtl/fsm_rr_arbiter.sv
// Round-robin arbiter for one shared resource with registered one-hot grants,
// a bounded hold time and a dead TURN cycle between owners.
module fsm_rr_arbiter
    import fsm_rr_arbiter_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 8
) (
    input logic            clk,
    input logic            reset,
    fsm_rr_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = clog2(N);

    state_e            r_state, w_state_d;
    logic [IDX_W-1:0]  r_ptr, w_ptr_d;
    logic [IDX_W-1:0]  r_owner, w_owner_d;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_d;
    logic [N-1:0]      r_grant, w_grant_d;
    logic              r_busy, w_busy_d;
    logic              r_expired, w_expired_d;
    logic [IDX_W-1:0]  w_winner;
    logic              w_any;
    logic [IDX_W-1:0]  w_owner_next;

    rr_priority_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    assign w_owner_next = (r_owner == IDX_W'(N - 1)) ? '0 : r_owner + IDX_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_hold_cnt <= '0;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_expired  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_ptr      <= w_ptr_d;
            r_owner    <= w_owner_d;
            r_hold_cnt <= w_hold_cnt_d;
            r_grant    <= w_grant_d;
            r_busy     <= w_busy_d;
            r_expired  <= w_expired_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_ptr_d      = r_ptr;
        w_owner_d    = r_owner;
        w_hold_cnt_d = r_hold_cnt;
        w_expired_d  = 1'b0;
        case (r_state)
            IDLE, TURN: begin
                if (w_any) begin
                    w_state_d    = BUSY;
                    w_owner_d    = w_winner;
                    w_hold_cnt_d = '0;
                end else begin
                    w_state_d = IDLE;
                end
            end
            BUSY: begin
                w_hold_cnt_d = r_hold_cnt + HOLD_W'(1);
                // A release wins over a simultaneous timeout, so expired stays low.
                if (!bus.req[r_owner]) begin
                    w_state_d = TURN;
                    w_ptr_d   = w_owner_next;
                end else if ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_W'(MAX_HOLD - 1))) begin
                    w_state_d   = TURN;
                    w_ptr_d     = w_owner_next;
                    w_expired_d = 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase

        // Grant and busy are registered images of the next state.
        w_grant_d = '0;
        if (w_state_d == BUSY) begin
            w_grant_d[w_owner_d] = 1'b1;
        end
        w_busy_d = (w_state_d == BUSY);
    end

    always_comb begin
        bus.next_grant = '0;
        if (((r_state == IDLE) || (r_state == TURN)) && w_any) begin
            bus.next_grant[w_winner] = 1'b1;
        end
    end

    assign bus.grant   = r_grant;
    assign bus.busy    = r_busy;
    assign bus.expired = r_expired;
endmodule
